// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared definitions for the parameterised serial transmitter:
//                FSM state encodings, parity mode encodings, clog2 helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // Parity mode encodings for the PARITY parameter
    localparam int c_PAR_NONE = 0;
    localparam int c_PAR_EVEN = 1;
    localparam int c_PAR_ODD  = 2;

    // Transmit FSM state encodings
    typedef logic [2:0] tx_state_t;
    localparam tx_state_t c_ST_IDLE  = 3'd0;
    localparam tx_state_t c_ST_START = 3'd1;
    localparam tx_state_t c_ST_DATA  = 3'd2;
    localparam tx_state_t c_ST_PAR   = 3'd3;
    localparam tx_state_t c_ST_STOP  = 3'd4;

    // Bits needed to hold values 0..value-1 (returns 0 for value <= 1)
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tx_fifo
//  Description : Synchronous DATA_W x DEPTH transmit FIFO. Pointers carry one
//                extra wrap bit so full and empty are distinguishable when the
//                address bits match. Head word is presented combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo
    import serial_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  logic [DATA_W-1:0]       i_data,
    input  logic                    i_pop,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_empty,
    output logic                    o_full,
    output logic [clog2(DEPTH):0]   o_count
);

    localparam int c_AW = clog2(DEPTH);

    logic [c_AW:0]       r_wr_ptr;
    logic [c_AW:0]       r_rd_ptr;
    logic [c_AW:0]       r_count;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_push;
    logic                w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_count = r_count;

    // Pointer and occupancy bookkeeping; reset flushes the buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset since empty pointers mask them
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/serial_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_param
//  Description : Buffered parallel-to-serial transmitter. Frames are a low
//                start bit, DATA_W data bits LSB first, optional parity and
//                STOP_BITS high stop bits, each CLKS_PER_BIT clocks long.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_param
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         load,
    input  logic [DATA_W-1:0]            fromCPU,
    output logic                         ready,
    output logic                         out,
    output logic                         busy,
    output logic                         charSent,
    output logic [clog2(FIFO_DEPTH):0]   fifo_count
);

    // Reject illegal configurations at elaboration
    if (PARITY != c_PAR_NONE && PARITY != c_PAR_EVEN && PARITY != c_PAR_ODD) begin : g_bad_parity
        $error("serial_tx_param: PARITY must be 0 (none), 1 (even) or 2 (odd)");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("serial_tx_param: STOP_BITS must be 1 or 2");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
        $error("serial_tx_param: DATA_W must be in 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_div
        $error("serial_tx_param: CLKS_PER_BIT must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("serial_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end

    localparam int                 c_TMR_W     = clog2(CLKS_PER_BIT);
    localparam int                 c_IDX_W     = clog2(DATA_W);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DATA_W - 1);
    localparam logic [c_IDX_W-1:0] c_STOP_LAST = c_IDX_W'(STOP_BITS - 1);

    tx_state_t           r_state;
    logic [c_TMR_W-1:0]  r_tmr;
    logic [c_IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0]   r_shift;
    logic                r_par;

    logic [DATA_W-1:0]   w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_tick;
    logic                w_last_stop;
    logic                w_can_start;
    logic                w_pop;
    logic                w_par_bit;

    tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (load),
        .i_data  (fromCPU),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (fifo_count)
    );

    assign w_tick      = (r_state != c_ST_IDLE) && (r_tmr == c_TMR_LAST);
    assign w_last_stop = (r_state == c_ST_STOP) && w_tick && (r_idx == c_STOP_LAST);
    assign w_can_start = enable && !w_empty;
    // A new word leaves the FIFO either from idle or seamlessly at frame end
    assign w_pop       = w_can_start && ((r_state == c_ST_IDLE) || w_last_stop);
    assign w_par_bit   = (PARITY == c_PAR_ODD) ? ~(^w_head) : (^w_head);

    assign ready    = !w_full;
    assign busy     = (r_state != c_ST_IDLE);
    assign charSent = w_last_stop;

    // Bit timer: free-runs over one bit period while a frame is active
    always_ff @(posedge clk) begin
        if (reset || w_pop || r_state == c_ST_IDLE || w_tick) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + c_TMR_W'(1);
        end
    end

    // Frame sequencer: walks start, data, parity and stop bits on timer ticks
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_par   <= w_par_bit;
                        r_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_tick) begin
                        r_idx   <= '0;
                        r_state <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_idx == c_IDX_LAST) begin
                            r_idx   <= '0;
                            r_state <= (PARITY != c_PAR_NONE) ? c_ST_PAR : c_ST_STOP;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                end
                c_ST_PAR: begin
                    if (w_tick) begin
                        r_idx   <= '0;
                        r_state <= c_ST_STOP;
                    end
                end
                c_ST_STOP: begin
                    if (w_tick) begin
                        if (r_idx == c_STOP_LAST) begin
                            r_idx <= '0;
                            if (w_pop) begin
                                r_shift <= w_head;
                                r_par   <= w_par_bit;
                                r_state <= c_ST_START;
                            end else begin
                                r_state <= c_ST_IDLE;
                            end
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Serial line level decoded from the current frame position
    always_comb begin
        out = 1'b1;
        case (r_state)
            c_ST_START: out = 1'b0;
            c_ST_DATA:  out = r_shift[0];
            c_ST_PAR:   out = r_par;
            default:    out = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx_param
//  Description : Scoreboard bench for two transmitter configurations
//                (8 data bits, 4 clocks/bit): even parity + 1 stop bit and
//                odd parity + 2 stop bits. Accepted words are queued by an
//                input monitor; a line monitor rebuilds each expected frame
//                and compares it sample by sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_param;

    localparam int c_DW    = 8;
    localparam int c_CPB   = 4;
    localparam int c_DEPTH = 4;
    localparam int c_CW    = 3;

    logic            clk     = 1'b0;
    logic            reset   = 1'b1;
    logic            enable  = 1'b0;
    logic            load    = 1'b0;
    logic [c_DW-1:0] fromCPU = '0;

    logic            w_ready [2];
    logic            w_out   [2];
    logic            w_busy  [2];
    logic            w_sent  [2];
    logic [c_CW-1:0] w_cnt   [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_tx_param #(
        .DATA_W(c_DW), .CLKS_PER_BIT(c_CPB), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(c_DEPTH)
    ) u_dut_even1 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .fromCPU    (fromCPU),
        .ready      (w_ready[0]),
        .out        (w_out[0]),
        .busy       (w_busy[0]),
        .charSent   (w_sent[0]),
        .fifo_count (w_cnt[0])
    );

    serial_tx_param #(
        .DATA_W(c_DW), .CLKS_PER_BIT(c_CPB), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(c_DEPTH)
    ) u_dut_odd2 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .fromCPU    (fromCPU),
        .ready      (w_ready[1]),
        .out        (w_out[1]),
        .busy       (w_busy[1]),
        .charSent   (w_sent[1]),
        .fifo_count (w_cnt[1])
    );

    function automatic void chk(input int id, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL dut%0d.%s: got %0h expected %0h at %0t", id, name, act, exp, $time);
    endfunction

    // Line image of a frame, bit 0 first: start, data LSB first, parity, then
    // all-ones so any number of stop bits reads high.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int par);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        if (par != 0) f[9] = (($countones(d) % 2) == 1) ^ (par == 2);
        return f;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_chk
        localparam int c_PAR = (g == 0) ? 1 : 2;
        localparam int c_SB  = (g == 0) ? 1 : 2;
        localparam int c_LEN = (1 + c_DW + 1 + c_SB) * c_CPB;

        logic [c_DW-1:0] q[$];

        // Input side: every word the buffer can take is expected on the line
        always @(posedge clk) begin
            if (reset) q.delete();
            else if (load && q.size() < c_DEPTH) q.push_back(fromCPU);
        end

        // Line side: compare every clock against the expected frame/idle level
        initial begin : mon
            int          pos;
            logic        start_pred;
            logic        rst_prev;
            logic [15:0] bits;
            pos        = -1;
            start_pred = 1'b0;
            rst_prev   = 1'b1;
            bits       = '1;
            forever begin
                @(negedge clk);
                if (rst_prev) begin
                    pos = -1;
                    chk(g, "rst_out",  w_out[g],  1);
                    chk(g, "rst_busy", w_busy[g], 0);
                    chk(g, "rst_sent", w_sent[g], 0);
                end else begin
                    if (pos < 0 && start_pred) begin
                        bits = frame_bits(q.pop_front(), c_PAR);
                        pos  = 0;
                    end
                    if (pos < 0) begin
                        chk(g, "idle_out",  w_out[g],  1);
                        chk(g, "idle_busy", w_busy[g], 0);
                        chk(g, "idle_sent", w_sent[g], 0);
                    end else begin
                        chk(g, $sformatf("bit%0d", pos / c_CPB), w_out[g], bits[pos / c_CPB]);
                        chk(g, "frame_busy", w_busy[g], 1);
                        chk(g, "charSent",  w_sent[g], (pos == c_LEN - 1) ? 1 : 0);
                        pos++;
                        if (pos == c_LEN) pos = -1;
                    end
                end
                chk(g, "fifo_count", w_cnt[g],   q.size());
                chk(g, "ready",      w_ready[g], (q.size() < c_DEPTH) ? 1 : 0);
                start_pred = !reset && enable && (pos < 0) && (q.size() > 0);
                rst_prev   = reset;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        load    = 1'b1;
        fromCPU = d;
        tick(1);
        load    = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int k;
        for (k = 0; k < max_cycles; k++) begin
            tick(1);
            if (!w_busy[0] && !w_busy[1] && w_cnt[0] == 0 && w_cnt[1] == 0) break;
        end
        if (k == max_cycles) begin
            n_checks++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", max_cycles);
        end
    endtask

    initial begin
        tick(3);
        reset  = 1'b0;
        enable = 1'b1;
        tick(2);

        // Single frames from idle
        send(8'hA5);
        drain(200);
        send(8'h00);
        drain(200);
        for (int i = 0; i < 3; i++) begin
            send(8'($urandom));
            drain(200);
        end

        // Fill while disabled: fifth word is dropped, then drain back-to-back
        enable = 1'b0;
        for (int i = 1; i <= 5; i++) send(8'(8'h11 * i));
        tick(2);
        for (int g = 0; g < 2; g++) begin
            chk(g, "full_ready", w_ready[g], 0);
            chk(g, "full_count", w_cnt[g],   4);
        end
        enable = 1'b1;
        drain(600);

        // Disable mid-frame with two words still queued
        for (int i = 0; i < 3; i++) send(8'($urandom));
        tick(20);
        enable = 1'b0;
        tick(60);
        for (int g = 0; g < 2; g++) begin
            chk(g, "hold_count", w_cnt[g],  2);
            chk(g, "hold_busy",  w_busy[g], 0);
            chk(g, "hold_line",  w_out[g],  1);
        end
        enable = 1'b1;
        drain(600);

        // Reset in the middle of the data bits, then a clean frame
        send(8'($urandom));
        send(8'($urandom));
        tick(16);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int g = 0; g < 2; g++) begin
            chk(g, "post_rst_out",   w_out[g],   1);
            chk(g, "post_rst_count", w_cnt[g],   0);
            chk(g, "post_rst_ready", w_ready[g], 1);
        end
        send(8'($urandom));
        drain(200);

        // Ten words through the four-entry buffer, pointers wrap
        for (int i = 0; i < 10; i++) begin
            for (int w = 0; w < 200 && !(w_ready[0] && w_ready[1]); w++) tick(1);
            send(8'($urandom));
            tick($urandom_range(0, 12));
        end
        drain(1500);

        // Random traffic with enable toggling and dropped writes
        for (int i = 0; i < 500; i++) begin
            enable  = ($urandom_range(0, 9) != 0);
            load    = ($urandom_range(0, 3) == 0);
            fromCPU = 8'($urandom);
            tick(1);
        end
        load   = 1'b0;
        enable = 1'b1;
        drain(2000);
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
